// File: rtl/freelist.sv
// freelist: physical-register free list for the 2-wide rename stage.
//   Allocates up to two pregs per cycle, takes back up to two stale pregs
//   per cycle from commit, and restores the speculative head on flush.
// Ports:
//   clk, reset (async, active-high)
//   rename2fl_instr{0,1}_alloc -> fl2rename_alloc_ready,
//     fl2rename_instr{0,1}_prd (combinational grant)
//   commit2fl_instr{0,1}_commit : advance the architectural head
//   commit2fl_free{0,1}_valid/_pnum : stale pregs appended at the tail
//   flush : spec_head <= arch_head (+ this cycle's commits)
//   fl_free_count : speculative free count, 0..DEPTH
//   fl_stall_cnt : only when FREELIST_STALL_CNT_EN is defined
module freelist #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_LREGS = 32,
    parameter int PREG_W    = 6,
    parameter int DEPTH     = NUM_PREGS - NUM_LREGS,
    parameter int PTR_W     = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rename2fl_instr0_alloc,
    input  logic              rename2fl_instr1_alloc,
    output logic              fl2rename_alloc_ready,
    output logic [PREG_W-1:0] fl2rename_instr0_prd,
    output logic [PREG_W-1:0] fl2rename_instr1_prd,
    input  logic              commit2fl_instr0_commit,
    input  logic              commit2fl_instr1_commit,
    input  logic              commit2fl_free0_valid,
    input  logic [PREG_W-1:0] commit2fl_free0_pnum,
    input  logic              commit2fl_free1_valid,
    input  logic [PREG_W-1:0] commit2fl_free1_pnum,
    input  logic              flush,
    output logic [PTR_W-1:0]  fl_free_count
`ifdef FREELIST_STALL_CNT_EN
    ,
    output logic [31:0]       fl_stall_cnt
`endif
);

    localparam int IDX_W = PTR_W - 1;

    logic [PREG_W-1:0] entries [DEPTH];

    logic [PTR_W-1:0] spec_head;
    logic [PTR_W-1:0] arch_head;
    logic [PTR_W-1:0] tail;

    logic [PTR_W-1:0] count;
    logic [PTR_W-1:0] req_n;
    logic [PTR_W-1:0] free_n;
    logic [PTR_W-1:0] cmt_n;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] head_idx1;
    logic [IDX_W-1:0] tail_idx;
    logic [IDX_W-1:0] tail_idx1;
    logic             alloc_fire;

    always_comb begin
        req_n  = PTR_W'(rename2fl_instr0_alloc)
               + PTR_W'(rename2fl_instr1_alloc);
        free_n = PTR_W'(commit2fl_free0_valid)
               + PTR_W'(commit2fl_free1_valid);
        cmt_n  = PTR_W'(commit2fl_instr0_commit)
               + PTR_W'(commit2fl_instr1_commit);
    end

    // Wrap bit makes tail - spec_head distinguish full from empty.
    assign count         = tail - spec_head;
    assign fl_free_count = count;

    assign head_idx  = spec_head[IDX_W-1:0];
    assign head_idx1 = head_idx + IDX_W'(1);
    assign tail_idx  = tail[IDX_W-1:0];
    assign tail_idx1 = tail_idx + IDX_W'(commit2fl_free0_valid);

    // All-or-nothing grant; never grant during a flush.
    assign fl2rename_alloc_ready = (count >= req_n) && !flush;
    assign alloc_fire = fl2rename_alloc_ready && (req_n != '0);

    assign fl2rename_instr0_prd = entries[head_idx];
    assign fl2rename_instr1_prd = rename2fl_instr0_alloc
                                ? entries[head_idx1]
                                : entries[head_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= PREG_W'(NUM_LREGS + i);
            end
            spec_head <= '0;
            arch_head <= '0;
            tail      <= PTR_W'(DEPTH);
        end else begin
            if (flush) begin
                spec_head <= arch_head + cmt_n;
            end else if (alloc_fire) begin
                spec_head <= spec_head + req_n;
            end
            arch_head <= arch_head + cmt_n;
            tail      <= tail + free_n;
            if (commit2fl_free0_valid) begin
                entries[tail_idx] <= commit2fl_free0_pnum;
            end
            if (commit2fl_free1_valid) begin
                entries[tail_idx1] <= commit2fl_free1_pnum;
            end
        end
    end

`ifdef FREELIST_STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fl_stall_cnt <= '0;
        end else if ((req_n != '0) && !fl2rename_alloc_ready
                     && !flush) begin
            fl_stall_cnt <= fl_stall_cnt + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    logic [PTR_W:0] fill_next;
    logic [PTR_W-1:0] in_flight;
    assign fill_next = {1'b0, count} + {1'b0, free_n};
    assign in_flight = spec_head - arch_head;

    always @(posedge clk) begin
        if (!reset) begin
            if (fill_next > (PTR_W+1)'(DEPTH)) begin
                $error("freelist: free overflows capacity");
            end
            if (in_flight < cmt_n) begin
                $error("freelist: commit passes spec_head");
            end
        end
    end
`endif

endmodule

// File: tb/tb_freelist.sv
// tb_freelist: directed self-checking bench for freelist.
//   One task per scenario, each with inline comparisons.
module tb_freelist;

    logic       clk = 1'b0;
    logic       reset;
    logic       a0, a1;
    logic       ready;
    logic [5:0] prd0, prd1;
    logic       c0, c1;
    logic       f0v, f1v;
    logic [5:0] f0p, f1p;
    logic       flush;
    logic [5:0] count;
`ifdef FREELIST_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    freelist dut (
        .clk                     (clk),
        .reset                   (reset),
        .rename2fl_instr0_alloc  (a0),
        .rename2fl_instr1_alloc  (a1),
        .fl2rename_alloc_ready   (ready),
        .fl2rename_instr0_prd    (prd0),
        .fl2rename_instr1_prd    (prd1),
        .commit2fl_instr0_commit (c0),
        .commit2fl_instr1_commit (c1),
        .commit2fl_free0_valid   (f0v),
        .commit2fl_free0_pnum    (f0p),
        .commit2fl_free1_valid   (f1v),
        .commit2fl_free1_pnum    (f1p),
        .flush                   (flush),
        .fl_free_count           (count)
`ifdef FREELIST_STALL_CNT_EN
        ,
        .fl_stall_cnt            (stall_cnt)
`endif
    );

    task automatic clear_in();
        a0 = 0; a1 = 0; c0 = 0; c1 = 0;
        f0v = 0; f1v = 0; f0p = '0; f1p = '0;
        flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1;
        tick();
        tick();
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (count !== 6'd32) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=32", count);
        end
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", ready);
        end
        checks++;
        if (prd0 !== 6'd32) begin
            failures++;
            $display("FAIL reset_prd0 got=%0d exp=32", prd0);
        end
    endtask

    task automatic test_both_alloc();
        do_reset();
        a0 = 1; a1 = 1;
        #1;
        checks++;
        if (prd0 !== 6'd32 || prd1 !== 6'd33 || ready !== 1'b1) begin
            failures++;
            $display("FAIL both_grant got=%0d/%0d/%b exp=32/33/1",
                     prd0, prd1, ready);
        end
        tick();
        clear_in();
        #1;
        checks++;
        if (count !== 6'd30 || prd0 !== 6'd34) begin
            failures++;
            $display("FAIL both_after got=%0d/%0d exp=30/34",
                     count, prd0);
        end
    endtask

    task automatic test_instr1_only();
        do_reset();
        a1 = 1;
        #1;
        checks++;
        if (prd1 !== 6'd32 || ready !== 1'b1) begin
            failures++;
            $display("FAIL i1_grant got=%0d/%b exp=32/1", prd1, ready);
        end
        tick();
        clear_in();
        #1;
        checks++;
        if (count !== 6'd31 || prd0 !== 6'd33) begin
            failures++;
            $display("FAIL i1_after got=%0d/%0d exp=31/33", count, prd0);
        end
    endtask

    task automatic test_exhaust();
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 31; i++) begin
            a0 = 1;
            #1;
            if (count !== 6'(32 - i) || prd0 !== 6'(32 + i)
                || ready !== 1'b1) begin
                bad++;
            end
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL exhaust_walk got=%0d bad steps exp=0", bad);
        end
        a0 = 1; a1 = 1;
        #1;
        checks++;
        if (ready !== 1'b0 || count !== 6'd1) begin
            failures++;
            $display("FAIL exhaust_both got=%b/%0d exp=0/1", ready, count);
        end
        tick();
        checks++;
        if (count !== 6'd1) begin
            failures++;
            $display("FAIL exhaust_hold got=%0d exp=1", count);
        end
        a1 = 0;
        #1;
        checks++;
        if (ready !== 1'b1 || prd0 !== 6'd63) begin
            failures++;
            $display("FAIL exhaust_last got=%b/%0d exp=1/63", ready, prd0);
        end
        tick();
        checks++;
        if (count !== 6'd0 || ready !== 1'b0) begin
            failures++;
            $display("FAIL empty_i0 got=%0d/%b exp=0/0", count, ready);
        end
        a0 = 0; a1 = 1;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL empty_i1 got=%b exp=0", ready);
        end
        clear_in();
    endtask

    // Continues from the empty state left by test_exhaust.
    task automatic test_wrap_free();
        a0 = 1; a1 = 1;
        f0v = 1; f0p = 6'd5;
        f1v = 1; f1p = 6'd9;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL nobypass_ready got=%b exp=0", ready);
        end
        tick();
        f0v = 0; f1v = 0;
        #1;
        checks++;
        if (count !== 6'd2 || prd0 !== 6'd5 || prd1 !== 6'd9
            || ready !== 1'b1) begin
            failures++;
            $display("FAIL wrap_grant got=%0d/%0d/%0d/%b exp=2/5/9/1",
                     count, prd0, prd1, ready);
        end
        tick();
        clear_in();
        #1;
        checks++;
        if (count !== 6'd0) begin
            failures++;
            $display("FAIL wrap_drain got=%0d exp=0", count);
        end
    endtask

    task automatic test_flush();
        do_reset();
        a0 = 1; a1 = 1;
        tick();
        tick();
        clear_in();
        #1;
        checks++;
        if (count !== 6'd28) begin
            failures++;
            $display("FAIL flush_pre got=%0d exp=28", count);
        end
        c0 = 1;
        tick();
        clear_in();
        flush = 1; c0 = 1; a0 = 1;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready got=%b exp=0", ready);
        end
        tick();
        clear_in();
        #1;
        checks++;
        if (count !== 6'd30 || prd0 !== 6'd34) begin
            failures++;
            $display("FAIL flush_after got=%0d/%0d exp=30/34",
                     count, prd0);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        a0 = 1;
        tick();
        tick();
        clear_in();
        #3;
        reset = 1;
        #1;
        checks++;
        if (count !== 6'd32 || prd0 !== 6'd32) begin
            failures++;
            $display("FAIL async_reset got=%0d/%0d exp=32/32",
                     count, prd0);
        end
        tick();
        reset = 0;
        #1;
    endtask

`ifdef FREELIST_STALL_CNT_EN
    task automatic test_stall_cnt();
        do_reset();
        a0 = 1;
        for (int i = 0; i < 31; i++) tick();
        checks++;
        if (stall_cnt !== 32'd0) begin
            failures++;
            $display("FAIL stall_zero got=%0d exp=0", stall_cnt);
        end
        a1 = 1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (stall_cnt !== 32'd5) begin
            failures++;
            $display("FAIL stall_five got=%0d exp=5", stall_cnt);
        end
        flush = 1;
        tick();
        checks++;
        if (stall_cnt !== 32'd5) begin
            failures++;
            $display("FAIL stall_flush got=%0d exp=5", stall_cnt);
        end
        clear_in();
    endtask
`endif

    initial begin
        clear_in();
        reset = 1;
        test_reset();
        test_both_alloc();
        test_instr1_only();
        test_exhaust();
        test_wrap_free();
        test_flush();
        test_async_reset();
`ifdef FREELIST_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
